// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes (fetch and data stage) plus the shared memory bus.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_done;
  logic [DATA_W-1:0]     if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;
  logic                  dm_done;
  logic [DATA_W-1:0]     dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stall_if;
  logic                  stall_mem;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_rdata,
    output if_done, if_rdata, dm_done, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (IF) and data (MEM)
// requesters; data wins by default, fetch wins after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg, state_next;
  logic                owner_if_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [STV_W-1:0]    starve_cnt_reg;
  logic                mem_en_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [BE_W-1:0]     mem_be_reg;
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [DATA_W-1:0]   dm_rdata_reg;

  logic                if_win;
  logic                dm_win;
  logic                access_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // IDLE and RESP both arbitrate, so back-to-back accesses cost MEM_LAT+1 cycles.
  always_comb begin
    state_next = state_reg;
    if_win     = 1'b0;
    dm_win     = 1'b0;
    access_end = 1'b0;
    case (state_reg)
      IDLE, RESP: begin
        if_win = bus.if_req && (!bus.dm_req || (starve_cnt_reg == STV_LIMIT));
        dm_win = bus.dm_req && !if_win;
        state_next = (if_win || dm_win) ? ACCESS : IDLE;
      end
      ACCESS: begin
        if (lat_cnt_reg == '0) begin
          access_end = 1'b1;
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_if_reg   <= 1'b0;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_be_reg     <= '0;
      if_rdata_reg   <= '0;
      dm_rdata_reg   <= '0;
    end else begin
      if (if_win || dm_win) begin
        owner_if_reg  <= if_win;
        lat_cnt_reg   <= LAT_INIT;
        mem_en_reg    <= 1'b1;
        mem_we_reg    <= dm_win && bus.dm_we;
        mem_addr_reg  <= if_win ? bus.if_addr : bus.dm_addr;
        mem_wdata_reg <= if_win ? '0 : bus.dm_wdata;
        mem_be_reg    <= if_win ? '0 : bus.dm_be;
      end else if (access_end) begin
        mem_en_reg <= 1'b0;
        mem_we_reg <= 1'b0;
        // Stores leave dm_rdata untouched; mem_we_reg still reflects the access here.
        if (owner_if_reg) begin
          if_rdata_reg <= bus.mem_rdata;
        end else if (!mem_we_reg) begin
          dm_rdata_reg <= bus.mem_rdata;
        end
      end else if (state_reg == ACCESS) begin
        lat_cnt_reg <= lat_cnt_reg - 1'b1;
      end

      if (!bus.if_req || if_win) begin
        starve_cnt_reg <= '0;
      end else if (dm_win && (starve_cnt_reg != STV_LIMIT)) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_be    = mem_be_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.if_done   = (state_reg == RESP) && owner_if_reg;
  assign bus.dm_done   = (state_reg == RESP) && !owner_if_reg;
  assign bus.stall_if  = bus.if_req && !bus.if_done;
  assign bus.stall_mem = bus.dm_req && !bus.dm_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a transaction-timing reference model (grant cycle + fixed latency arithmetic).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int BE_W       = DATA_W / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks_cnt = 0;
  int fail_cnt   = 0;

  // Reference model: the last grant and the cycle it happened in fully determine
  // the memory window, the done cycle and the capture cycle.
  int                cyc;
  bit                has_g;
  int                g_cyc;
  bit                g_if;
  bit                g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [BE_W-1:0]   g_be;
  int                starve;
  logic [DATA_W-1:0] exp_if_rdata;
  logic [DATA_W-1:0] exp_dm_rdata;
  int                mode;
  int                done_code;
  int                done_seen;

  task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic model_reset();
    has_g        = 1'b0;
    g_cyc        = 0;
    starve       = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    cyc          = 0;
  endtask

  task automatic check_reset_values();
    check_value("rst_mem_en",    bus.mem_en,    0);
    check_value("rst_mem_we",    bus.mem_we,    0);
    check_value("rst_mem_addr",  bus.mem_addr,  0);
    check_value("rst_mem_wdata", bus.mem_wdata, 0);
    check_value("rst_mem_be",    bus.mem_be,    0);
    check_value("rst_if_done",   bus.if_done,   0);
    check_value("rst_dm_done",   bus.dm_done,   0);
    check_value("rst_if_rdata",  bus.if_rdata,  0);
    check_value("rst_dm_rdata",  bus.dm_rdata,  0);
  endtask

  // mode 0: random traffic, 1: both requesters held, 2: caller-driven, 3: drop req on done
  task automatic drive_stimulus(input bit if_done_now, input bit dm_done_now);
    case (mode)
      0: begin
        if (bus.if_req) begin
          if (if_done_now) begin
            if ($urandom_range(1, 0) == 1) bus.if_req = 1'b0;
            else bus.if_addr = $urandom;
          end else if ($urandom_range(99, 0) < 3) begin
            bus.if_req = 1'b0;
          end
        end else if ($urandom_range(99, 0) < 40) begin
          bus.if_req  = 1'b1;
          bus.if_addr = $urandom;
        end
        if (bus.dm_req) begin
          if (dm_done_now) begin
            if ($urandom_range(1, 0) == 1) bus.dm_req = 1'b0;
            else begin
              bus.dm_we    = 1'($urandom_range(1, 0));
              bus.dm_addr  = $urandom;
              bus.dm_wdata = $urandom;
              bus.dm_be    = BE_W'($urandom);
            end
          end else if ($urandom_range(99, 0) < 3) begin
            bus.dm_req = 1'b0;
          end
        end else if ($urandom_range(99, 0) < 50) begin
          bus.dm_req   = 1'b1;
          bus.dm_we    = 1'($urandom_range(1, 0));
          bus.dm_addr  = $urandom;
          bus.dm_wdata = $urandom;
          bus.dm_be    = BE_W'($urandom);
        end
      end
      1: begin
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
      end
      3: begin
        if (if_done_now) bus.if_req = 1'b0;
        if (dm_done_now) bus.dm_req = 1'b0;
      end
      default: ;
    endcase
    bus.mem_rdata = $urandom;
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    bit e_en, e_ifd, e_dmd, wi, wd, can_arb;
    e_en  = has_g && (cyc > g_cyc) && (cyc <= g_cyc + MEM_LAT);
    e_ifd = has_g && (cyc == g_cyc + MEM_LAT + 1) && g_if;
    e_dmd = has_g && (cyc == g_cyc + MEM_LAT + 1) && !g_if;
    drive_stimulus(e_ifd, e_dmd);
    #1;
    check_value("mem_en",    bus.mem_en,    e_en);
    check_value("mem_we",    bus.mem_we,    e_en && g_we);
    check_value("if_done",   bus.if_done,   e_ifd);
    check_value("dm_done",   bus.dm_done,   e_dmd);
    check_value("stall_if",  bus.stall_if,  bus.if_req && !e_ifd);
    check_value("stall_mem", bus.stall_mem, bus.dm_req && !e_dmd);
    check_value("if_rdata",  bus.if_rdata,  exp_if_rdata);
    check_value("dm_rdata",  bus.dm_rdata,  exp_dm_rdata);
    if (e_en) begin
      check_value("mem_addr", bus.mem_addr, g_addr);
      check_value("mem_be",   bus.mem_be,   g_be);
      if (!g_if) check_value("mem_wdata", bus.mem_wdata, g_wdata);
    end
    if (bus.if_done)
      $display("[cyc %0d] IF  fetch addr=0x%08h rdata=0x%08h", cyc, g_addr, bus.if_rdata);
    if (bus.dm_done)
      $display("[cyc %0d] MEM %s addr=0x%08h wdata=0x%08h rdata=0x%08h", cyc,
               g_we ? "store" : "load ", g_addr, g_wdata, bus.dm_rdata);
    if (mode == 1 && done_seen < 6 && (bus.if_done || bus.dm_done)) begin
      done_code = done_code * 2 + int'(bus.if_done);
      done_seen++;
    end
    // Read data is taken from the last cycle of the access window.
    if (has_g && cyc == g_cyc + MEM_LAT) begin
      if (g_if) exp_if_rdata = bus.mem_rdata;
      else if (!g_we) exp_dm_rdata = bus.mem_rdata;
    end
    can_arb = !has_g || (cyc >= g_cyc + MEM_LAT + 1);
    wi = can_arb && bus.if_req && (!bus.dm_req || starve == STARVE_MAX);
    wd = can_arb && bus.dm_req && !wi;
    if (wi || wd) begin
      has_g   = 1'b1;
      g_cyc   = cyc;
      g_if    = wi;
      g_we    = wd && bus.dm_we;
      g_addr  = wi ? bus.if_addr : bus.dm_addr;
      g_wdata = bus.dm_wdata;
      g_be    = wi ? '0 : bus.dm_be;
    end
    if (!bus.if_req || wi) starve = 0;
    else if (wd && starve < STARVE_MAX) starve++;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_be     = '0;
    bus.mem_rdata = '0;
    mode          = 2;
    done_code     = 0;
    done_seen     = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    model_reset();

    // Single fetch at 0x100
    mode = 3;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    repeat (6) step();

    // Fetch and load together: load first, fetch granted in the RESP cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h2000;
    repeat (9) step();

    // Store
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'hDEADBEEF;
    bus.dm_be    = 4'hF;
    repeat (5) step();

    // Load whose request drops right after grant
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b0;
    bus.dm_addr = 32'h80;
    step();
    bus.dm_req = 1'b0;
    repeat (5) step();

    // Starvation: both held, expect MEM,MEM,MEM,MEM,IF,MEM
    mode        = 1;
    done_code   = 0;
    done_seen   = 0;
    bus.if_addr = 32'h500;
    bus.dm_addr = 32'h600;
    bus.dm_we   = 1'b0;
    repeat (20) step();
    check_value("starve_order", done_code, 2);
    check_value("starve_count", done_seen, 6);
    mode = 2;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (5) step();

    // Asynchronous reset in the first access cycle of a load
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h2000;
    step();
    check_value("rst_pre_en", bus.mem_en, 1);
    #1 reset = 1'b1;
    #1;
    check_value("rst_async_en", bus.mem_en, 0);
    check_value("rst_async_done", bus.dm_done, 0);
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    model_reset();
    mode = 3;
    repeat (6) step();

    // Random traffic
    mode = 0;
    repeat (1500) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM).
- Grants one access at a time and holds the memory interface stable for the full access latency.
- Returns read data or a write acknowledge to the granted requester.
- Generates per-requester stall outputs, which pipeline control uses to build its stall/flush decisions.

Parameters:
ADDR_W, 32, width of all address buses
DATA_W, 32, width of data buses
MEM_LAT, 2, memory access latency in cycles (valid range >= 1)
STARVE_MAX, 4, consecutive MEM grants allowed while IF waits before IF is forced to win

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  fetch read request, level, held until if_done
if_addr  input  ADDR_W  fetch address
if_done  output  1  one-cycle pulse: fetch access complete, if_rdata valid
if_rdata  output  DATA_W  fetch read data, registered
dm_req  input  1  data request, level, held until dm_done
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_be  input  DATA_W/8  store byte enables
dm_done  output  1  one-cycle pulse: data access complete (load data valid / store committed)
dm_rdata  output  DATA_W  load data, registered
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_be  output  DATA_W/8  memory byte enables
mem_rdata  input  DATA_W  memory read data, valid in the last cycle of an access
stall_if  output  1  if_req & ~if_done (combinational)
stall_mem  output  1  dm_req & ~dm_done (combinational)

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, latency counter = 0, starvation counter = 0.
  - All mem_* outputs 0; if_done = dm_done = 0; if_rdata = dm_rdata = 0.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE and RESP both arbitrate.
  - RESP additionally drives the done pulse for the access that just finished.
- Arbitration (evaluated in IDLE/RESP):
  - Default priority: dm_req over if_req.
  - If starve_cnt == STARVE_MAX and if_req = 1, IF wins.
  - starve_cnt increments on each MEM grant while if_req = 1, saturating at STARVE_MAX.
  - starve_cnt clears on any IF grant and whenever if_req = 0.
- Grant: at the edge ending an arbitration cycle with a winner:
  - state -> ACCESS, owner is recorded, lat_cnt = MEM_LAT-1.
  - mem_en = 1; mem_addr, mem_we, mem_wdata and mem_be are registered from the winner.
  - For IF grants, mem_we = 0 and mem_be = 0.
  - All mem_* outputs are held constant for exactly MEM_LAT cycles.
- ACCESS: lat_cnt decrements each cycle. When lat_cnt == 0:
  - mem_rdata is captured into the owner's rdata register; the other requester's rdata is unchanged.
  - mem_en/mem_we drop to 0; state -> RESP.
- RESP (exactly one cycle):
  - The owner's done output is 1.
  - A new arbitration occurs in this same cycle. A requester still asserting req is treated as making a new request.
  - If there is no winner, state -> IDLE.
- Timing:
  - A request winning in cycle N has mem_en high during N+1..N+MEM_LAT and done in cycle N+MEM_LAT+1.
  - Peak throughput is one access per MEM_LAT+1 cycles.
- A request that loses arbitration stalls; its stall output stays 1 until its done pulse.
- Requester drops req mid-access: the access still completes and done still pulses. Requesters must not change addr/data while req is high; the arbiter samples them only at grant.
- Stores: mem_rdata is ignored and dm_rdata is unchanged; dm_done still pulses.
- Simultaneous if_req and dm_req in IDLE: MEM wins unless the starvation rule applies.
- Reset mid-access: abort immediately. No done pulse, mem_en = 0 asynchronously, the in-flight access is discarded.
- Exactly one of if_done / dm_done can be 1 in any cycle. mem_en is never 1 in IDLE or RESP.

Test Plan:
- MEM_LAT=2, if_req=1, addr 0x100, dm_req=0 -> mem_en high 2 cycles with mem_addr=0x100, mem_we=0; if_done pulses 3 cycles after request; if_rdata = mem_rdata from the 2nd access cycle; stall_if high for 3 cycles.
- if_req and dm_req (load 0x2000) asserted together -> MEM granted first, dm_done at +3; IF granted in the RESP cycle, if_done at +6.
- dm_req held high for 6 back-to-back loads with if_req=1, STARVE_MAX=4 -> grants MEM,MEM,MEM,MEM,IF,MEM; starve_cnt clears after the IF grant.
- Store dm_we=1, addr 0x40, wdata 0xDEADBEEF, be=0xF -> mem_we=1 with those values for 2 cycles; dm_done pulses; dm_rdata unchanged.
- reset asserted asynchronously in the first ACCESS cycle of a load -> mem_en falls without a clock edge; no dm_done; after release the state is IDLE and a re-asserted dm_req is granted normally.
- dm_req dropped after grant -> access completes and dm_done pulses once; the arbiter returns to IDLE with mem_en=0.
